alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issues one operation at a time to the combinational ALU (`arithmetic_logic`) through a valid/ready request port and drives its one-hot operation lines and operands. It captures the ALU result into a register and returns it through a one-cycle response strobe. It repeats shift operations (`lsx`, `lsy`) a programmable number of times by feeding each result back as the next operand. It sits between the CPU control unit and the ALU and is the only driver of the ALU control lines.

## Interface
- No parameters; all widths fixed (8-bit data, 4-bit opcode, 3-bit repeat count).
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present; requester holds `req_*` stable until accepted
- `req_ready`  out  1  sequencer idle, request accepted on `req_valid && req_ready`
- `req_op`  in  4  opcode; selects one ALU line (mapping below)
- `req_x`, `req_y`  in  8 each  operands
- `req_cnt`  in  3  shift repeat count; passes = `req_cnt`+1; ignored for non-shift ops
- `alu_ctl`  out  16  one-hot ALU lines, bit order: 0 add, 1 sub, 2 amp, 3 lor, 4 flp, 5 eor, 6 lsx, 7 lsy, 8 prc0, 9 prc1, 10 prc2, 11 prc4, 12 prc8, 13 prgl, 14 prgh, 15 eql
- `alu_x`, `alu_y`  out  8 each  ALU operands, driven from the internal operand registers
- `alu_res`  in  8  ALU result, combinational from `alu_ctl`/`alu_x`/`alu_y`
- `rsp_valid`  out  1  one-cycle pulse, result available
- `rsp_res`  out  8  last captured result; held until the next capture
- `busy`  out  1  high in EXEC and DONE

## Operation
- FSM states: IDLE, EXEC, DONE. `req_ready` = (state == IDLE).
- IDLE:
  - On accept, latch `req_x`/`req_y` into opx/opy and `req_op` into op.
  - Load pass counter `rem` = `req_cnt` if op is 6 or 7, else 0.
  - Go to EXEC.
- EXEC:
  - `alu_ctl` = 1<<op (exactly one bit set); `alu_x`=opx, `alu_y`=opy.
  - Each edge: `rsp_res` <= `alu_res`.
  - If `rem`≠0: decrement `rem`. For op 6, opx <= `alu_res`. For op 7, opy <= `alu_res`. Stay in EXEC.
  - If `rem`=0: go to DONE.
- DONE:
  - `rsp_valid`=1 for this cycle only, `alu_ctl`=0.
  - Next state is IDLE unconditionally. A request cannot be accepted in DONE.
- `alu_ctl` is all-zero in IDLE and DONE. It is never multi-hot.
- `alu_x` and `alu_y` hold the last operand values outside EXEC; they are don't-care to the ALU.
- All 16 opcodes are legal. Repeat counting applies only to opcodes 6 and 7.
- `req_cnt`=7 gives 8 passes, which is the maximum. The counter never wraps below 0.

## Timing
- Reset (async assert, synchronous-release flops):
  - State IDLE.
  - `req_ready`=1, `busy`=0, `rsp_valid`=0.
  - `rsp_res`=0x00, `alu_ctl`=0, `alu_x`=`alu_y`=0x00.
  - `rem`=0, op=0.
- Latency, with the accept edge as edge 0:
  - EXEC occupies cycles 1..N, where N = number of passes.
  - `rsp_valid` is high in cycle N+1.
  - `req_ready` returns high in cycle N+2.
- Single-pass op: `rsp_valid` 2 cycles after accept. Throughput is one op per 3 cycles.
- `req_valid` asserted while `req_ready`=0: no effect. The request is taken on the first IDLE cycle.
- Reset mid-EXEC or in DONE:
  - Immediately IDLE, `alu_ctl`=0.
  - No `rsp_valid` is emitted for the aborted op.
  - `rsp_res` is cleared to 0x00.
- `req_*` inputs are sampled only at the accept edge. Changes afterwards do not affect the op in flight.

## Test plan
All scenarios use the real `arithmetic_logic` for the ALU, except where noted.
- Reset:
  - Stimulus: assert `rst_n`=0 mid-cycle.
  - Required response: outputs at reset values asynchronously, `req_ready`=1, `alu_ctl`=0.
- Add:
  - Stimulus: op 0, x=13, y=12.
  - Required response: `alu_ctl`=0x0001 for exactly 1 cycle, then `rsp_valid` pulse with `rsp_res`=25, 2 cycles after accept.
  - Stimulus: x=165, y=0xFF.
  - Required response: `rsp_res`=164.
- Sub and amp:
  - Stimulus: op 1 with x=77, y=27.
  - Required response: `rsp_res`=50.
  - Stimulus: op 2 with x=0xFC, y=0x3F.
  - Required response: `rsp_res`=0x3C, `alu_ctl`=0x0004.
- Repeated shift (bench ALU model: `lsx` = x<<1):
  - Stimulus: op 6, x=0x01, cnt=2.
  - Required response: `alu_ctl`=0x0040 for 3 consecutive cycles, then `rsp_res`=0x08, `rsp_valid` 4 cycles after accept.
  - Stimulus: cnt=7, x=0x01.
  - Required response: `rsp_res`=0x00 after 8 passes, with no counter wrap.
- Back-to-back:
  - Stimulus: `req_valid` held high with the add request, then the sub request queued behind it.
  - Required response: second accept in the cycle after the first `rsp_valid`, and never while `busy`=1. The sub's operands are unchanged by edits to `req_*` made after its accept.
- Reset mid-shift:
  - Stimulus: op 6, cnt=5; `rst_n` low in the 2nd EXEC cycle.
  - Required response: no `rsp_valid`, `rsp_res`=0x00, `alu_ctl`=0. After release, a new add 1+1 returns 2.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Hands one operation at a time to the combinational ALU (arithmetic_logic).
// A request is accepted on req_valid && req_ready. The sequencer then drives the
// one-hot ALU control lines and the operands, and captures the ALU result into
// rsp_res. It reports completion with a one-cycle rsp_valid strobe. The two
// shift opcodes (lsx = 6, lsy = 7) run req_cnt + 1 passes. Each pass result is
// fed back as the next operand.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present, req_* held stable until accepted
//   req_ready  high in IDLE; a request is taken on req_valid && req_ready
//   req_op     4-bit opcode, selects ALU line 1 << req_op
//   req_x/y    8-bit operands
//   req_cnt    shift repeat count (passes = req_cnt + 1), ignored for non-shifts
//   alu_ctl    16-bit one-hot ALU operation lines, all-zero outside EXEC
//   alu_x/y    ALU operands from the internal operand registers
//   alu_res    ALU result, combinational from alu_ctl/alu_x/alu_y
//   rsp_valid  one-cycle completion strobe
//   rsp_res    last captured ALU result, held until the next capture
//   busy       high in EXEC and DONE

module alu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [7:0]  req_x,
    input  logic [7:0]  req_y,
    input  logic [2:0]  req_cnt,
    output logic [15:0] alu_ctl,
    output logic [7:0]  alu_x,
    output logic [7:0]  alu_y,
    input  logic [7:0]  alu_res,
    output logic        rsp_valid,
    output logic [7:0]  rsp_res,
    output logic        busy
);

    localparam logic [3:0] OpLsx = 4'd6;
    localparam logic [3:0] OpLsy = 4'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [7:0]  opx_q, opx_d;
    logic [7:0]  opy_q, opy_d;
    logic [2:0]  rem_q, rem_d;
    logic [7:0]  res_q, res_d;
    logic        req_is_shift;

    assign req_is_shift = (req_op == OpLsx) || (req_op == OpLsy);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_q    <= 4'd0;
            opx_q   <= 8'h00;
            opy_q   <= 8'h00;
            rem_q   <= 3'd0;
            res_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opx_q   <= opx_d;
            opy_q   <= opy_d;
            rem_q   <= rem_d;
            res_q   <= res_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        opx_d   = opx_q;
        opy_d   = opy_q;
        rem_d   = rem_q;
        res_d   = res_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    opx_d   = req_x;
                    opy_d   = req_y;
                    // rem counts passes still to run after the current one
                    rem_d   = req_is_shift ? req_cnt : 3'd0;
                    state_d = StExec;
                end
            end
            StExec: begin
                res_d = alu_res;
                if (rem_q != 3'd0) begin
                    rem_d = rem_q - 3'd1;
                    // Feed the shifted value back as the operand for the next pass
                    if (op_q == OpLsx) begin
                        opx_d = alu_res;
                    end
                    if (op_q == OpLsy) begin
                        opy_d = alu_res;
                    end
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from the state register
    always_comb begin
        alu_ctl = 16'h0000;
        if (state_q == StExec) begin
            alu_ctl = 16'h0001 << op_q;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q == StExec) || (state_q == StDone);
    assign rsp_valid = (state_q == StDone);
    assign rsp_res   = res_q;
    assign alu_x     = opx_q;
    assign alu_y     = opy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural ALU stands in for arithmetic_logic.
// A scoreboard model is compared against the DUT on every falling edge.
// Directed requests also carry hand-computed expected results and latencies.

module tb_alu_sequencer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [7:0]  req_x;
    logic [7:0]  req_y;
    logic [2:0]  req_cnt;
    logic [15:0] alu_ctl;
    logic [7:0]  alu_x;
    logic [7:0]  alu_y;
    logic [7:0]  alu_res;
    logic        rsp_valid;
    logic [7:0]  rsp_res;
    logic        busy;

    int n_chk;
    int n_fail;

    alu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_cnt   (req_cnt),
        .alu_ctl   (alu_ctl),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_res   (alu_res),
        .rsp_valid (rsp_valid),
        .rsp_res   (rsp_res),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference operation for one pass of opcode op
    function automatic logic [7:0] ref_op(input logic [3:0] op, input logic [7:0] x,
                                          input logic [7:0] y);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd4:    return ~x;
            4'd5:    return x ^ y;
            4'd6:    return {x[6:0], 1'b0};
            4'd7:    return {y[6:0], 1'b0};
            4'd8:    return 8'h00;
            4'd9:    return 8'h01;
            4'd10:   return 8'h02;
            4'd11:   return 8'h04;
            4'd12:   return 8'h08;
            4'd13:   return y & 8'h0F;
            4'd14:   return y & 8'hF0;
            default: return (x == y) ? 8'h01 : 8'h00;
        endcase
    endfunction

    // Stand-in ALU: decodes the one-hot lines; a non-one-hot control gives a marker value
    function automatic logic [7:0] bench_alu(input logic [15:0] ctl, input logic [7:0] x,
                                             input logic [7:0] y);
        if ($countones(ctl) != 1) return 8'hEE;
        for (int i = 0; i < 16; i++) begin
            if (ctl[i]) return ref_op(4'(i), x, y);
        end
        return 8'hEE;
    endfunction

    always_comb alu_res = bench_alu(alu_ctl, alu_x, alu_y);

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model. It precomputes all passes of an accepted request,
    // then walks through them one cycle at a time.
    bit         m_act;
    int         m_c;
    int         m_n;
    logic [3:0] m_op;
    logic [7:0] m_res [8];
    logic [7:0] m_px  [8];
    logic [7:0] m_py  [8];
    logic [7:0] m_rsp;
    logic [7:0] m_ax;
    logic [7:0] m_ay;

    initial begin
        m_act = 1'b0;
        m_c   = 0;
        m_n   = 1;
        m_op  = 4'd0;
        m_rsp = 8'h00;
        m_ax  = 8'h00;
        m_ay  = 8'h00;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_act = 1'b0;
                m_rsp = 8'h00;
                m_ax  = 8'h00;
                m_ay  = 8'h00;
            end else if (!m_act) begin
                if (req_valid) begin
                    logic [7:0] x;
                    logic [7:0] y;
                    logic [7:0] r;
                    x    = req_x;
                    y    = req_y;
                    m_op = req_op;
                    m_n  = (req_op == 4'd6 || req_op == 4'd7) ? int'(req_cnt) + 1 : 1;
                    for (int p = 0; p < m_n; p++) begin
                        m_px[p]  = x;
                        m_py[p]  = y;
                        r        = ref_op(req_op, x, y);
                        m_res[p] = r;
                        if (req_op == 4'd6) x = r;
                        if (req_op == 4'd7) y = r;
                    end
                    m_act = 1'b1;
                    m_c   = 1;
                    m_ax  = m_px[0];
                    m_ay  = m_py[0];
                end
            end else begin
                if (m_c <= m_n) m_rsp = m_res[m_c-1];
                m_c++;
                if (m_c <= m_n) begin
                    m_ax = m_px[m_c-1];
                    m_ay = m_py[m_c-1];
                end
                if (m_c == m_n + 2) m_act = 1'b0;
            end
        end
    end

    // Compare the DUT against the model on every falling edge
    initial begin
        forever begin
            logic [15:0] exp_ctl;
            @(negedge clk);
            exp_ctl = (m_act && m_c <= m_n) ? (16'h0001 << m_op) : 16'h0000;
            chk("sb_req_ready", 16'(req_ready), 16'(!m_act));
            chk("sb_busy", 16'(busy), 16'(m_act));
            chk("sb_rsp_valid", 16'(rsp_valid), 16'(m_act && m_c == m_n + 1));
            chk("sb_alu_ctl", alu_ctl, exp_ctl);
            chk("sb_rsp_res", 16'(rsp_res), 16'(m_rsp));
            chk("sb_alu_x", 16'(alu_x), 16'(m_ax));
            chk("sb_alu_y", 16'(alu_y), 16'(m_ay));
        end
    end

    // Present a request and wait (bounded) until the edge where it is accepted.
    // Returns #1 after the accept edge with req_valid still high.
    task automatic send(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y,
                        input logic [2:0] cnt, output int waits);
        req_op    = op;
        req_x     = x;
        req_y     = y;
        req_cnt   = cnt;
        req_valid = 1'b1;
        waits     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            waits++;
            if (req_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("accept_timeout", 16'(waits), 16'd0);
    endtask

    // Wait (bounded) for rsp_valid. Count the cycles since accept, and the
    // cycles in which alu_ctl showed the required value.
    task automatic wait_rsp(input logic [15:0] exp_ctl, output int lat, output int ctl_cycles);
        lat        = 0;
        ctl_cycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (alu_ctl == exp_ctl) ctl_cycles++;
            if (rsp_valid) return;
        end
        chk("rsp_timeout", 16'(lat), 16'd0);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [7:0] x,
                          input logic [7:0] y, input logic [2:0] cnt, input logic [7:0] exp_res,
                          input int exp_lat, input logic [15:0] exp_ctl);
        int waits;
        int lat;
        int ctl_cycles;
        send(op, x, y, cnt, waits);
        req_valid = 1'b0;
        // Disturb the request inputs after the accept; the op in flight must ignore them
        req_x     = 8'hA5;
        req_y     = 8'h5A;
        req_op    = 4'd15;
        req_cnt   = 3'd7;
        wait_rsp(exp_ctl, lat, ctl_cycles);
        chk({name, "_res"}, 16'(rsp_res), 16'(exp_res));
        chk({name, "_lat"}, 16'(lat), 16'(exp_lat));
        chk({name, "_ctl_cycles"}, 16'(ctl_cycles), 16'(exp_lat - 1));
    endtask

    initial begin
        int waits;
        int lat;
        int ctl_cycles;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_x     = 8'h00;
        req_y     = 8'h00;
        req_cnt   = 3'd0;

        #3;
        chk("rst_req_ready", 16'(req_ready), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
        chk("rst_alu_ctl", alu_ctl, 16'h0000);
        chk("rst_rsp_res", 16'(rsp_res), 16'h0000);
        chk("rst_alu_xy", {alu_x, alu_y}, 16'h0000);
        #19;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add", 4'd0, 8'd13, 8'd12, 3'd0, 8'd25, 2, 16'h0001);
        run_op("add_wrap", 4'd0, 8'd165, 8'hFF, 3'd0, 8'd164, 2, 16'h0001);
        run_op("add_cnt_ignored", 4'd0, 8'd2, 8'd3, 3'd5, 8'd5, 2, 16'h0001);
        run_op("sub", 4'd1, 8'd77, 8'd27, 3'd0, 8'd50, 2, 16'h0002);
        run_op("amp", 4'd2, 8'hFC, 8'h3F, 3'd0, 8'h3C, 2, 16'h0004);
        run_op("lor", 4'd3, 8'hF0, 8'h0F, 3'd0, 8'hFF, 2, 16'h0008);
        run_op("flp", 4'd4, 8'h5A, 8'h00, 3'd0, 8'hA5, 2, 16'h0010);
        run_op("eor", 4'd5, 8'hFF, 8'h0F, 3'd0, 8'hF0, 2, 16'h0020);
        run_op("lsx3", 4'd6, 8'h01, 8'h00, 3'd2, 8'h08, 4, 16'h0040);
        run_op("lsx8", 4'd6, 8'h01, 8'h00, 3'd7, 8'h00, 9, 16'h0040);
        run_op("lsy4", 4'd7, 8'h00, 8'h03, 3'd3, 8'h30, 5, 16'h0080);
        run_op("prc1", 4'd9, 8'h00, 8'h00, 3'd0, 8'h01, 2, 16'h0200);
        run_op("eql", 4'd15, 8'h09, 8'h09, 3'd0, 8'h01, 2, 16'h8000);

        // Back-to-back: the sub request is queued while the add is in flight
        send(4'd0, 8'd13, 8'd12, 3'd0, waits);
        req_op  = 4'd1;
        req_x   = 8'd77;
        req_y   = 8'd27;
        req_cnt = 3'd0;
        wait_rsp(16'h0001, lat, ctl_cycles);
        chk("b2b_add_res", 16'(rsp_res), 16'd25);
        chk("b2b_add_lat", 16'(lat), 16'd2);
        send(4'd1, 8'd77, 8'd27, 3'd0, waits);
        chk("b2b_second_accept_wait", 16'(waits), 16'd1);
        req_valid = 1'b0;
        req_x     = 8'h00;
        req_y     = 8'hFF;
        wait_rsp(16'h0002, lat, ctl_cycles);
        chk("b2b_sub_res", 16'(rsp_res), 16'd50);
        chk("b2b_sub_lat", 16'(lat), 16'd2);

        // Reset during the second EXEC cycle of a six-pass shift
        send(4'd6, 8'h01, 8'h00, 3'd5, waits);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_ctl", alu_ctl, 16'h0000);
        chk("mid_rst_rsp_res", 16'(rsp_res), 16'h0000);
        chk("mid_rst_ready", 16'(req_ready), 16'd1);
        chk("mid_rst_rsp_valid", 16'(rsp_valid), 16'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("mid_rst_no_rsp", 16'(rsp_valid), 16'd0);
        end
        @(posedge clk);
        #1;
        run_op("post_rst_add", 4'd0, 8'd1, 8'd1, 3'd0, 8'd2, 2, 16'h0001);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
